// File: rtl/jk_stim_checker_if.sv
// Handshake and J/K drive bundle between the stimulus checker and its user.
// slave: the checker. master: whoever drives start/mode/len and returns Q.
interface jk_stim_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [7:0]       len;
    logic             q_in;
    logic             j;
    logic             k;
    logic             busy;
    logic             done;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output start, mode, len, q_in,
        input  j, k, busy, done, err, err_cnt
    );

    modport slave (
        input  start, mode, len, q_in,
        output j, k, busy, done, err, err_cnt
    );
endinterface

// File: rtl/jk_stim_checker.sv
// Self-checking J/K stimulus generator. Drives programmable J/K patterns into
// a downstream JK flip-flop, tracks the expected Q with its own model and
// counts every cycle where the returned Q disagrees.
module jk_stim_checker #(
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         ERR_W     = 8
) (
    input logic              clk,
    input logic              rst,
    jk_stim_checker_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_mode;
    logic [7:0]       r_len;
    logic [7:0]       r_step, w_step_nxt;
    logic [7:0]       r_lfsr, w_lfsr_nxt;
    logic             r_j, r_k, w_j_nxt, w_k_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_drain, w_drain_nxt;
    logic             r_exp_q, r_chk_en, r_err;
    logic [ERR_W-1:0] r_err_cnt;
    logic             w_start_ok, w_pat_j, w_pat_k, w_cmp_en, w_miss;

    // J/K value for the current pattern step
    always_comb begin
        w_pat_j = 1'b0;
        w_pat_k = 1'b0;
        case (r_mode)
            2'b00:   {w_pat_j, w_pat_k} = r_step[1:0];
            2'b01:   {w_pat_j, w_pat_k} = 2'b11;
            2'b10:   {w_pat_j, w_pat_k} = {r_lfsr[0], r_lfsr[1]};
            default: {w_pat_j, w_pat_k} = r_step[0] ? 2'b01 : 2'b10;
        endcase
    end

    // Next state and next registered outputs. done/busy are registered on the
    // edge leaving DONE, so done lands while the FSM is back in IDLE; a start
    // seen alongside done is therefore rejected explicitly.
    always_comb begin
        w_state_nxt = r_state;
        w_j_nxt     = 1'b0;
        w_k_nxt     = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_step_nxt  = r_step;
        w_lfsr_nxt  = r_lfsr;
        w_drain_nxt = r_drain;
        w_start_ok  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !r_done) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = S_INIT;
                    w_k_nxt     = 1'b1;     // J/K = 01 forces the unknown Q to 0
                    w_busy_nxt  = 1'b1;
                    w_step_nxt  = 8'd0;
                    w_lfsr_nxt  = LFSR_SEED;
                end
            end
            S_INIT, S_RUN: begin
                // step is 0 in INIT, so this also covers len == 0
                if (r_step == r_len) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_RUN;
                    w_j_nxt     = w_pat_j;
                    w_k_nxt     = w_pat_k;
                    w_step_nxt  = r_step + 8'd1;
                    w_lfsr_nxt  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
                end
            end
            S_DRAIN: begin
                if (r_drain) w_state_nxt = S_DONE;
                else         w_drain_nxt = 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state, drive registers and run configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_step  <= 8'd0;
            r_lfsr  <= LFSR_SEED;
            r_drain <= 1'b0;
            r_mode  <= 2'b00;
            r_len   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_step  <= w_step_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_drain <= w_drain_nxt;
            if (w_start_ok) begin
                r_mode <= bus.mode;
                r_len  <= bus.len;
            end
        end
    end

    assign w_cmp_en = ((r_state == S_RUN) || (r_state == S_DRAIN)) && r_chk_en;
    assign w_miss   = w_cmp_en && (bus.q_in != r_exp_q);

    // Reference JK model plus sticky error flag and saturating miss counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp_q   <= 1'b0;
            r_chk_en  <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (r_state == S_INIT) begin
                r_exp_q  <= 1'b0;
                r_chk_en <= 1'b1;
            end else if (r_state != S_IDLE) begin
                case ({r_j, r_k})
                    2'b01:   r_exp_q <= 1'b0;
                    2'b10:   r_exp_q <= 1'b1;
                    2'b11:   r_exp_q <= ~r_exp_q;
                    default: r_exp_q <= r_exp_q;
                endcase
            end
            if (r_state == S_DONE) r_chk_en <= 1'b0;
            if (w_start_ok) begin
                r_err     <= 1'b0;
                r_err_cnt <= '0;
            end else if (w_miss) begin
                r_err <= 1'b1;
                if (r_err_cnt != {ERR_W{1'b1}}) r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    assign bus.j       = r_j;
    assign bus.k       = r_k;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.err_cnt = r_err_cnt;
endmodule

// File: tb/tb_jk_stim_checker.sv
// Bench for jk_stim_checker: a behavioural JK flip-flop closes the loop, and a
// run-level model derives the expected J/K trace, handshake timing and error
// count straight from the pattern and JK rules.
module tb_jk_stim_checker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jk_stim_checker_if #(.ERR_W(8)) bus();
    jk_stim_checker #(.LFSR_SEED(8'hA5), .ERR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // downstream flip-flop; powers up at 1 so the forced clear is visible
    logic ff_q = 1'b1;
    int   qsel = 0;   // 0: real flip-flop, 1: Q stuck at 0, 2: inverted Q
    always @(posedge clk)
        case ({bus.j, bus.k})
            2'b01: ff_q <= 1'b0;
            2'b10: ff_q <= 1'b1;
            2'b11: ff_q <= ~ff_q;
            default: ;
        endcase
    assign bus.q_in = (qsel == 0) ? ff_q : (qsel == 1) ? 1'b0 : ~ff_q;

    // captured per-cycle outputs, index n = cycle after edge e(n)
    logic [1:0] cap_jk [0:263];
    logic       cap_busy [0:263];
    logic       cap_done [0:263];
    logic       cap_err0, cap_err;
    logic [7:0] cap_cnt0, cap_cnt;

    // model expectations
    logic [1:0] exp_jk [0:263];
    logic       exp_err;
    int         exp_cnt;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic jk_apply(input logic q, input logic [1:0] jk);
        case (jk)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    task automatic model_run(input logic [1:0] m, input int L, input int qs);
        logic [7:0] l;
        logic       q;
        int         miss;
        l = 8'hA5;
        exp_jk[0] = 2'b01;
        for (int i = 0; i < L; i++) begin
            case (m)
                2'b00: exp_jk[i+1] = 2'(i % 4);
                2'b01: exp_jk[i+1] = 2'b11;
                2'b10: begin exp_jk[i+1] = {l[0], l[1]}; l = lfsr_next(l); end
                default: exp_jk[i+1] = (i % 2 == 0) ? 2'b10 : 2'b01;
            endcase
        end
        for (int n = L + 1; n <= L + 5; n++) exp_jk[n] = 2'b00;
        // compares see the flip-flop state after e1 .. e(L+2)
        q = 1'b0;
        miss = 0;
        for (int t = 1; t <= L + 2; t++) begin
            if (qs == 1 && q != 1'b0) miss++;
            if (qs == 2) miss++;
            q = jk_apply(q, exp_jk[t]);
        end
        exp_cnt = (miss > 255) ? 255 : miss;
        exp_err = (miss > 0);
    endtask

    // one run: start at e0, capture cycles 0..L+5; hold keeps start high
    // (with scrambled mode/len) through the done cycle
    task automatic do_run(input logic [1:0] m, input int L, input int qs, input bit hold);
        @(negedge clk);
        qsel = qs;
        bus.mode = m;
        bus.len = 8'(L);
        bus.start = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= L + 5; n++) begin
            @(negedge clk);
            cap_jk[n]   = {bus.j, bus.k};
            cap_busy[n] = bus.busy;
            cap_done[n] = bus.done;
            if (n == 0) begin cap_err0 = bus.err; cap_cnt0 = bus.err_cnt; end
            if (n == L + 4) begin cap_err = bus.err; cap_cnt = bus.err_cnt; end
            bus.start = hold && (n <= L + 4);
            if (hold) begin bus.mode = 2'($urandom); bus.len = 8'($urandom); end
        end
        bus.start = 1'b0;
        model_run(m, L, qs);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.mode = 2'b00; bus.len = 8'd0; qsel = 0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.j, bus.k, bus.busy, bus.done, bus.err} !== 5'b0 || bus.err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state jkbde=%b cnt=%0d want 0", {bus.j, bus.k, bus.busy, bus.done, bus.err}, bus.err_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        qsel = 1; bus.mode = 2'b01; bus.len = 8'd20; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.err !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prerun busy=%b err=%b want 1 1", bus.busy, bus.err);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.j, bus.k, bus.busy, bus.done, bus.err} !== 5'b0 || bus.err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_async jkbde=%b cnt=%0d want 0", {bus.j, bus.k, bus.busy, bus.done, bus.err}, bus.err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            n_tests++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_quiet cyc%0d busy=%b done=%b want 0 0", n, bus.busy, bus.done);
            end
        end
        qsel = 0;
    endtask

    task automatic test_walk();
        logic [1:0] plan [0:6];
        plan = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
        do_run(2'b00, 4, 0, 1'b0);
        for (int n = 0; n <= 9; n++) begin
            n_tests++;
            if (cap_jk[n] !== exp_jk[n] || cap_busy[n] !== (n <= 7) || cap_done[n] !== (n == 8)) begin
                n_fail++;
                $display("FAIL walk cyc%0d jk=%b busy=%b done=%b want %b %b %b",
                         n, cap_jk[n], cap_busy[n], cap_done[n], exp_jk[n], n <= 7, n == 8);
            end
        end
        for (int n = 0; n <= 6; n++) begin
            n_tests++;
            if (cap_jk[n] !== plan[n]) begin
                n_fail++;
                $display("FAIL walk_plan cyc%0d jk=%b want %b", n, cap_jk[n], plan[n]);
            end
        end
        n_tests++;
        if (cap_err !== 1'b0 || cap_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL walk_err err=%b cnt=%0d want 0 0", cap_err, cap_cnt);
        end
    endtask

    task automatic test_toggle_stuck();
        do_run(2'b01, 4, 1, 1'b0);
        for (int n = 0; n <= 9; n++) begin
            n_tests++;
            if (cap_jk[n] !== exp_jk[n] || cap_busy[n] !== (n <= 7) || cap_done[n] !== (n == 8)) begin
                n_fail++;
                $display("FAIL toggle cyc%0d jk=%b busy=%b done=%b want %b %b %b",
                         n, cap_jk[n], cap_busy[n], cap_done[n], exp_jk[n], n <= 7, n == 8);
            end
        end
        n_tests++;
        if (cap_err !== 1'b1 || cap_cnt !== 8'd2 || exp_cnt != 2) begin
            n_fail++;
            $display("FAIL toggle_err err=%b cnt=%0d want 1 2 (model %0d)", cap_err, cap_cnt, exp_cnt);
        end
    endtask

    task automatic test_len0();
        do_run(2'b11, 0, 0, 1'b0);
        for (int n = 0; n <= 5; n++) begin
            n_tests++;
            if (cap_jk[n] !== exp_jk[n] || cap_busy[n] !== (n <= 3) || cap_done[n] !== (n == 4)) begin
                n_fail++;
                $display("FAIL len0 cyc%0d jk=%b busy=%b done=%b want %b %b %b",
                         n, cap_jk[n], cap_busy[n], cap_done[n], exp_jk[n], n <= 3, n == 4);
            end
        end
        n_tests++;
        if (cap_err !== 1'b0 || cap_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL len0_err err=%b cnt=%0d want 0 0", cap_err, cap_cnt);
        end
        // inverted Q: both drain compares must miss
        do_run(2'b11, 0, 2, 1'b0);
        n_tests++;
        if (cap_err !== 1'b1 || cap_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL len0_cmpcount err=%b cnt=%0d want 1 2", cap_err, cap_cnt);
        end
    endtask

    task automatic test_random();
        logic [1:0] first [0:263];
        int diffs;
        do_run(2'b10, 255, 0, 1'b0);
        for (int n = 0; n <= 260; n++) begin
            n_tests++;
            if (cap_jk[n] !== exp_jk[n] || cap_busy[n] !== (n <= 258) || cap_done[n] !== (n == 259)) begin
                n_fail++;
                $display("FAIL random cyc%0d jk=%b busy=%b done=%b want %b %b %b",
                         n, cap_jk[n], cap_busy[n], cap_done[n], exp_jk[n], n <= 258, n == 259);
            end
            first[n] = cap_jk[n];
        end
        n_tests++;
        if (cap_err !== 1'b0 || cap_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL random_err err=%b cnt=%0d want 0 0", cap_err, cap_cnt);
        end
        do_run(2'b10, 255, 0, 1'b0);
        diffs = 0;
        for (int n = 0; n <= 260; n++) if (cap_jk[n] !== first[n]) diffs++;
        n_tests++;
        if (diffs != 0) begin
            n_fail++;
            $display("FAIL random_repeat differing cycles=%0d want 0", diffs);
        end
    endtask

    task automatic test_saturate();
        do_run(2'b01, 255, 2, 1'b0);
        n_tests++;
        if (cap_err !== 1'b1 || cap_cnt !== 8'd255 || exp_cnt != 255) begin
            n_fail++;
            $display("FAIL saturate err=%b cnt=%0d want 1 255", cap_err, cap_cnt);
        end
        do_run(2'b00, 3, 0, 1'b0);
        n_tests++;
        if (cap_err0 !== 1'b0 || cap_cnt0 !== 8'd0) begin
            n_fail++;
            $display("FAIL sticky_clear err=%b cnt=%0d want 0 0", cap_err0, cap_cnt0);
        end
        n_tests++;
        if (cap_err !== 1'b0 || cap_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL clean_after err=%b cnt=%0d want 0 0", cap_err, cap_cnt);
        end
    endtask

    // random runs; some hold start high through busy and the done cycle
    task automatic test_back_to_back();
        for (int r = 0; r < 12; r++) begin
            logic [1:0] m;
            int L, qs;
            bit hold;
            m = 2'($urandom);
            L = $urandom_range(0, 40);
            qs = $urandom_range(0, 2);
            hold = 1'($urandom);
            do_run(m, L, qs, hold);
            for (int n = 0; n <= L + 5; n++) begin
                n_tests++;
                if (cap_jk[n] !== exp_jk[n] || cap_busy[n] !== (n <= L + 3) || cap_done[n] !== (n == L + 4)) begin
                    n_fail++;
                    $display("FAIL b2b run%0d m=%0d L=%0d cyc%0d jk=%b busy=%b done=%b want %b %b %b",
                             r, m, L, n, cap_jk[n], cap_busy[n], cap_done[n], exp_jk[n], n <= L + 3, n == L + 4);
                end
            end
            n_tests++;
            if (cap_err !== exp_err || cap_cnt !== 8'(exp_cnt)) begin
                n_fail++;
                $display("FAIL b2b_err run%0d err=%b cnt=%0d want %b %0d", r, cap_err, cap_cnt, exp_err, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_toggle_stuck();
        test_len0();
        test_random();
        test_saturate();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
